// File: rtl/flash_read_arbiter_pkg.sv
// Shared types and constants for the two-requester flash read arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

  localparam int         NREQ         = 2;
  localparam logic [3:0] FLASH_BYTEEN = 4'b1111;
  localparam logic [6:0] FLASH_BURST  = 7'd1;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester-side bus (master = requesters, slave = arbiter) and
// flash-side Avalon-MM read bus (master = arbiter, slave = flash IP).
interface flash_req_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  import flash_arb_pkg::*;

  logic [NREQ-1:0]             s_read;
  logic [NREQ-1:0][ADDR_W-1:0] s_address;
  logic [NREQ-1:0]             s_waitrequest;
  logic [DATA_W-1:0]           s_readdata;
  logic [NREQ-1:0]             s_readdatavalid;
  logic                        s_error;

  modport master (output s_read, s_address,
                  input  s_waitrequest, s_readdata, s_readdatavalid, s_error);
  modport slave  (input  s_read, s_address,
                  output s_waitrequest, s_readdata, s_readdatavalid, s_error);
endinterface

interface flash_mem_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;
  logic [3:0]        flash_mem_byteenable;
  logic [6:0]        flash_mem_burstcount;

  modport master (output flash_mem_read, flash_mem_address, flash_mem_byteenable,
                         flash_mem_burstcount,
                  input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid);
  modport slave  (input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
                         flash_mem_burstcount,
                  output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid);
endinterface

// File: rtl/flash_read_arbiter_rr_pick2.sv
// Two-way round-robin pick: the requester that did not win last time is
// preferred when both ask; otherwise whoever is asking wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       any
);
  assign any     = |req;
  assign gnt_idx = (&req) ? ~last : req[1];
endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one flash Avalon-MM read port between two requesters, one single-word
// read in flight at a time, with a watchdog that aborts reads that never return.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  flash_req_if.slave     req,
  flash_mem_if.master    mem,
  output logic           timeout_sticky
);
  localparam int TW = $clog2(TIMEOUT);

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     timer;
  logic              pick_idx;
  logic              pick_any;

  rr_pick2 u_pick (
    .req     (req.s_read),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      grant               <= 1'b0;
      last_grant          <= 1'b1;
      addr_q              <= '0;
      timer               <= '0;
      req.s_readdata      <= '0;
      req.s_readdatavalid <= '0;
      req.s_error         <= 1'b0;
      timeout_sticky      <= 1'b0;
    end else begin
      req.s_readdatavalid <= '0;
      req.s_error         <= 1'b0;
      case (state)
        IDLE: if (pick_any) begin
          grant  <= pick_idx;
          addr_q <= req.s_address[pick_idx];
          state  <= ISSUE;
        end
        ISSUE: if (!mem.flash_mem_waitrequest) begin
          timer <= '0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          timer <= timer + 1'b1;
          // A valid on the last allowed cycle still wins over the abort.
          if (mem.flash_mem_readdatavalid) begin
            req.s_readdata             <= mem.flash_mem_readdata;
            req.s_readdatavalid[grant] <= 1'b1;
            state                      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            req.s_readdata             <= '0;
            req.s_readdatavalid[grant] <= 1'b1;
            req.s_error                <= 1'b1;
            timeout_sticky             <= 1'b1;
            state                      <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept is combinational so the requester sees it on the same cycle the flash does.
  always_comb begin
    req.s_waitrequest        = '1;
    mem.flash_mem_read       = (state == ISSUE);
    mem.flash_mem_address    = addr_q;
    mem.flash_mem_byteenable = FLASH_BYTEEN;
    mem.flash_mem_burstcount = FLASH_BURST;
    if (state == ISSUE && !mem.flash_mem_waitrequest)
      req.s_waitrequest[grant] = 1'b0;
  end

endmodule
